uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   UART receiver. It is the line-side counterpart of the SOC UART transmitter.
//   It samples the asynchronous serial input i_rx, recovers 8N1 frames (1 start bit,
//   8 data bits LSB first, 1 stop bit) and presents each byte with a one-cycle valid strobe.
//   It sits between the board RX pin and the SOC UART register/FIFO logic.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit (N); legal range 4..255
//   (derived) HALF = CLKS_PER_BIT/2, integer division; sets the mid-bit sample point
// PORTS
//   clk          in   1  system clock; all state on posedge
//   reset        in   1  asynchronous, active-low reset
//   i_rx         in   1  serial line, idle high, asynchronous to clk
//   o_data       out  8  last received byte
//   o_valid      out  1  one-cycle strobe; o_data holds a good byte
//   o_frame_err  out  1  one-cycle strobe; stop bit sampled low
//   o_busy       out  1  high while state != IDLE
// BEHAVIOUR
//   Reset (reset=0, async):
//     - state=IDLE; o_data=8'h00; o_valid=0; o_frame_err=0; o_busy=0.
//     - Synchronizer flops preset to 1.
//     - Reset mid-frame aborts the frame; no strobe is emitted for it.
//   Synchronizer:
//     - i_rx passes through 2 flops to give rx_s; only rx_s is used by the FSM.
//   Counters:
//     - cnt: 8-bit sample counter, cleared on every state entry.
//     - bit_idx: 3-bit data-bit index. It is not wrapped past 7; DATA exits at bit 7.
//   FSM states:
//     - IDLE: rx_s==0 -> START, cnt=0.
//     - START: cnt++ until cnt==HALF-1; on that cycle sample rx_s.
//         rx_s==1 -> IDLE (glitch, no strobe).
//         rx_s==0 -> DATA, cnt=0, bit_idx=0.
//     - DATA: cnt++ until cnt==N-1; on that cycle:
//         shift <= {rx_s, shift[7:1]}, cnt=0, bit_idx++.
//         After bit_idx==7 is sampled -> STOP.
//     - STOP: cnt++ until cnt==N-1; on that cycle sample rx_s.
//         rx_s==1 -> o_data<=shift, o_valid<=1, go IDLE.
//         rx_s==0 -> o_frame_err<=1, o_data unchanged, go WAIT.
//     - WAIT: stay until rx_s==1 -> IDLE.
//         A low line (break) must not start a new frame.
//   Outputs:
//     - o_valid and o_frame_err are high for exactly 1 cycle and never together.
//     - o_data is stable until the next good frame.
//   Latency:
//     - Let edge k be the first posedge at which i_rx is low.
//     - The strobe is registered at edge k+2+HALF+9*N. For N=16 that is k+154.
//   Back-to-back frames:
//     - A start bit beginning right after the stop bit's mid-point is accepted.
//     - No idle gap is needed, so continuous traffic at nominal rate loses no bytes.
//   Baud tolerance:
//     - Mid-bit sampling tolerates roughly +/-4% accumulated clock mismatch over a frame.
// TESTING
//   1. N=16, send 0xA5 8N1 -> one o_valid pulse at k+154, o_data=8'hA5, o_frame_err never high.
//   2. Back-to-back 0x00, 0xFF, 0x3C, no idle gap -> three o_valid pulses 160 cycles apart,
//      bytes in that order.
//   3. i_rx low for 4 cycles, then high -> state returns to IDLE; no strobe; o_busy high <=12 cycles.
//   4. Send 0x55 with stop bit low, line held low 500 cycles -> o_frame_err 1 cycle,
//      o_data keeps previous byte, no new frame until line high; then 0x12 received correctly.
//   5. Assert reset during bit 4 of 0xC3 -> all outputs 0 immediately (async); no strobe;
//      next frame 0x7E received correctly.
//   6. Loopback through the SOC UART transmitter with matching bit timing, bytes 0x00..0xFF
//      -> all 256 bytes received in order, zero framing errors.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, recovered byte and strobes out.
interface uart_rx_if;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    modport master (
        input  i_rx,
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_busy
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM,
// one-cycle valid / frame-error strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int         HALF    = CLKS_PER_BIT / 2;
    localparam logic [7:0] HALF_M1 = 8'(HALF - 1);
    localparam logic [7:0] BIT_M1  = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       rx_s;

    assign sync1_d = bus.i_rx;
    assign sync2_d = sync1_q;
    assign rx_s    = sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            // Idle line is high, so preset avoids a false start after reset.
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    // A start bit that is already gone by mid-bit was a glitch.
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT: begin
                // A held-low (break) line must go high before any new frame.
                if (rx_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frame_err = ferr_q;
    assign bus.o_busy      = (state_q != IDLE);

endmodule
